// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default widths, master ids and lock states.
package mem_pkg;

  localparam int unsigned AW_DEF       = 8;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned LOCK_MAX_DEF = 64;

  typedef enum logic {
    M_CPU = 1'b0,
    M_LDR = 1'b1
  } mst_id_e;

  typedef enum logic {
    L_FREE = 1'b0,
    L_HELD = 1'b1
  } lock_state_e;

  function automatic mst_id_e other_mst(mst_id_e m);
    return (m == M_CPU) ? M_LDR : M_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the master that was not granted last wins.
module rr_pick2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_id_e    last_i,
  output logic [1:0] gnt_o
);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (other_mst(last_i) == M_CPU) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port sync-read memory between the CPU (m0) and the loader (m1).
// Optional bus locking with a watchdog is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_err
);

  logic [1:0] req_v, we_v, req_eff, pick, gnt;
  logic [1:0] rvalid_q;
  mst_id_e    last_q, gnt_id, brk_id;
  logic       brk;

  assign req_v = {m1_req, m0_req};
  assign we_v  = {m1_we, m0_we};

`ifdef MEM_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  lock_state_e   lock_st_q;
  mst_id_e       owner_q;
  logic [CW-1:0] cnt_q;
  logic          lock_err_q;
  logic [1:0]    lock_v;

  assign lock_v = {m1_lock, m0_lock};

  // While held, only the owner may compete; an idle owner leaves the memory idle.
  always_comb begin
    req_eff = req_v;
    if (lock_st_q == L_HELD) begin
      req_eff = (owner_q == M_CPU) ? {1'b0, req_v[0]} : {req_v[1], 1'b0};
    end
  end

  assign brk      = (lock_st_q == L_HELD) && (cnt_q == CW'(LOCK_MAX - 1));
  assign brk_id   = owner_q;
  assign lock_err = lock_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_st_q  <= L_FREE;
      owner_q    <= M_CPU;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_err_q <= 1'b0;
      case (lock_st_q)
        L_FREE: begin
          if (|gnt && lock_v[gnt_id]) begin
            lock_st_q <= L_HELD;
            owner_q   <= gnt_id;
            cnt_q     <= '0;
          end
        end
        L_HELD: begin
          // The watchdog wins over a renewed lock request in the same cycle.
          if (brk) begin
            lock_st_q  <= L_FREE;
            cnt_q      <= '0;
            lock_err_q <= 1'b1;
          end else if (!lock_v[owner_q]) begin
            lock_st_q <= L_FREE;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: lock_st_q <= L_FREE;
      endcase
    end
  end
`else
  logic unused_lock;

  assign req_eff     = req_v;
  assign brk         = 1'b0;
  assign brk_id      = M_LDR;
  assign lock_err    = 1'b0;
  assign unused_lock = ^{m0_lock, m1_lock, 1'(LOCK_MAX)};
`endif

  rr_pick2 u_pick (
    .req_i  (req_eff),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign gnt    = pick & {2{rst_n}};
  assign gnt_id = gnt[1] ? M_LDR : M_CPU;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt[1]) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= M_LDR;
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= gnt & ~we_v;
      if (brk) begin
        last_q <= brk_id;
      end else if (|gnt) begin
        last_q <= gnt_id;
      end
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_mem_arbiter;

  localparam int LOCK_MAX_TB = 4;
`ifdef MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic [1:0] p_req, p_we, p_lock;
  logic [7:0] p_addr [2];
  logic [7:0] p_wdata[2];
  logic [1:0] n_req, n_we, n_lock;
  logic [7:0] n_addr [2];
  logic [7:0] n_wdata[2];

  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, lock_err;
  logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem_tb [256];
  logic [7:0] shadow [256];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int         m_last, m_owner, m_cnt, last_g;
  bit         m_locked, exp_lerr;
  bit [1:0]   exp_rv;
  logic [7:0] exp_rd;

  mem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(LOCK_MAX_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(p_req[0]), .m0_we(p_we[0]), .m0_addr(p_addr[0]), .m0_wdata(p_wdata[0]),
    .m0_lock(p_lock[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(p_req[1]), .m1_we(p_we[1]), .m1_addr(p_addr[1]), .m1_wdata(p_wdata[1]),
    .m1_lock(p_lock[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with one-cycle synchronous read.
  always @(posedge clk) begin
    mem_rdata <= mem_tb[mem_addr];
    if (mem_we) mem_tb[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_last   = 1;
    m_locked = 1'b0;
    m_owner  = 0;
    m_cnt    = 0;
    exp_rv   = 2'b00;
    exp_lerr = 1'b0;
    last_g   = -1;
  endfunction

  function automatic int pick_model();
    bit c0 = p_req[0];
    bit c1 = p_req[1];
    if (LOCK_EN && m_locked) begin
      if (m_owner == 0) c1 = 1'b0;
      else              c0 = 1'b0;
    end
    if (c0 && c1) return 1 - m_last;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  function automatic void advance(int g);
    bit [1:0]   nrv = 2'b00;
    logic [7:0] nrd = exp_rd;
    bit         nl  = 1'b0;
    if (g >= 0) begin
      if (p_we[g]) shadow[p_addr[g]] = p_wdata[g];
      else begin
        nrv[g] = 1'b1;
        nrd    = shadow[p_addr[g]];
      end
      m_last = g;
    end
    if (LOCK_EN) begin
      if (m_locked) begin
        m_cnt++;
        if (m_cnt == LOCK_MAX_TB) begin
          m_locked = 1'b0;
          m_cnt    = 0;
          nl       = 1'b1;
          m_last   = m_owner;
        end else if ((g == m_owner && !p_lock[g]) ||
                     (!p_req[m_owner] && !p_lock[m_owner])) begin
          m_locked = 1'b0;
          m_cnt    = 0;
        end
      end else if (g >= 0 && p_lock[g]) begin
        m_locked = 1'b1;
        m_owner  = g;
        m_cnt    = 0;
      end
    end
    exp_rv   = nrv;
    exp_rd   = nrd;
    exp_lerr = nl;
  endfunction

  // One clock cycle: apply next inputs at negedge, compare, then advance the model.
  task automatic step();
    int g;
    @(negedge clk);
    p_req  = n_req;
    p_we   = n_we;
    p_lock = n_lock;
    for (int m = 0; m < 2; m++) begin
      p_addr[m]  = n_addr[m];
      p_wdata[m] = n_wdata[m];
    end
    #1;
    g = pick_model();
    check("gnt0", 32'(m0_gnt), 32'(g == 0));
    check("gnt1", 32'(m1_gnt), 32'(g == 1));
    check("mem_we", 32'(mem_we), (g >= 0) ? 32'(p_we[g]) : 32'd0);
    check("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(p_addr[g]) : 32'd0);
    if (g >= 0 && p_we[g]) check("mem_wdata", 32'(mem_wdata), 32'(p_wdata[g]));
    check("rvalid0", 32'(m0_rvalid), 32'(exp_rv[0]));
    check("rvalid1", 32'(m1_rvalid), 32'(exp_rv[1]));
    if (exp_rv[0]) check("rdata0", 32'(m0_rdata), 32'(exp_rd));
    if (exp_rv[1]) check("rdata1", 32'(m1_rdata), 32'(exp_rd));
    check("lock_err", 32'(lock_err), 32'(exp_lerr));
    advance(g);
    last_g = g;
  endtask

  task automatic set_m(input int m, input bit req, input bit we, input logic [7:0] addr,
                       input logic [7:0] wdata, input bit lock);
    n_req[m]   = req;
    n_we[m]    = we;
    n_addr[m]  = addr;
    n_wdata[m] = wdata;
    n_lock[m]  = lock;
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_m(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    idle_all();
    @(negedge clk);
    p_req  = 2'b00;
    p_lock = 2'b00;
    rst_n  = 1'b0;
    #1;
    check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    check("rst_lock_err", 32'(lock_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    p_req = 2'b00; p_we = 2'b00; p_lock = 2'b00;
    for (int m = 0; m < 2; m++) begin
      p_addr[m] = 8'h00; p_wdata[m] = 8'h00;
    end
    idle_all();
    for (int i = 0; i < 256; i++) begin
      mem_tb[i] = 8'($urandom);
      shadow[i] = mem_tb[i];
    end
    mem_tb[0] = 8'h61; mem_tb[1] = 8'h72; mem_tb[2] = 8'h11; mem_tb[3] = 8'hF0;
    for (int i = 0; i < 4; i++) shadow[i] = mem_tb[i];
    model_reset();
    exp_rd = 8'h00;

    do_reset();

    // Both masters read every cycle: grants alternate starting with m0.
    set_m(0, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
    set_m(1, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t2_alt", 32'(m0_gnt), 32'(k % 2 == 0));
      if (k > 0) check("t2_route", 32'(m0_rvalid), 32'((k - 1) % 2 == 0));
      if (last_g >= 0) n_addr[last_g] = n_addr[last_g] + 8'd1;
    end
    idle_all();
    step();

    // Only m0 reads 0x00..0x03 back to back.
    for (int i = 0; i < 5; i++) begin
      logic [7:0] exp_t1 [4];
      exp_t1 = '{8'h61, 8'h72, 8'h11, 8'hF0};
      set_m(0, i < 4, 1'b0, 8'(i), 8'h00, 1'b0);
      step();
      if (i < 4) check("t1_gnt", 32'(m0_gnt), 32'd1);
      if (i > 0) begin
        check("t1_rvalid", 32'(m0_rvalid), 32'd1);
        check("t1_rdata", 32'(m0_rdata), 32'(exp_t1[i - 1]));
      end
    end

    // Write by m1 then read of the same address by m0.
    idle_all();
    set_m(1, 1'b1, 1'b1, 8'h10, 8'hAA, 1'b0);
    step();
    idle_all();
    set_m(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    step();
    check("t3_no_wr_rvalid", 32'(m1_rvalid), 32'd0);
    idle_all();
    step();
    check("t3_rvalid", 32'(m0_rvalid), 32'd1);
    check("t3_rdata", 32'(m0_rdata), 32'hAA);

`ifdef MEM_ARB_LOCK_EN
    // m1 locks for three writes while m0 waits.
    set_m(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      set_m(1, 1'b1, 1'b1, 8'(8'h30 + k), 8'(k + 1), k < 2);
      step();
      check("t4_blocked", 32'(m0_gnt), 32'd0);
    end
    n_req[1] = 1'b0;
    step();
    check("t4_release", 32'(m0_gnt), 32'd1);
    idle_all();
    step();

    // m1 keeps the lock until the watchdog breaks it.
    set_m(0, 1'b1, 1'b0, 8'h21, 8'h00, 1'b0);
    set_m(1, 1'b1, 1'b1, 8'h40, 8'h55, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t5_lock_err", 32'(lock_err), 32'(k == 6));
      check("t5_m0_gnt", 32'(m0_gnt), 32'(k == 6));
    end
    n_req[0] = 1'b0;
    step();
    set_m(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) step();
`endif

    // Random traffic; an ungranted request is held until granted.
    for (int c = 0; c < 500; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!(p_req[m] && last_g != m)) begin
          set_m(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3) == 0);
        end
      end
      step();
    end
    idle_all();
    repeat (LOCK_MAX_TB + 2) step();

    // Reset while a read is in flight.
    set_m(0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    step();
    @(posedge clk);
    #1;
    check("t6_rv_pre", 32'(m0_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rv_drop", 32'(m0_rvalid), 32'd0);
    check("t6_gnt_rst", 32'({m1_gnt, m0_gnt}), 32'd0);
    check("t6_we_rst", 32'(mem_we), 32'd0);
    p_req = 2'b00;
    idle_all();
    repeat (2) begin
      @(negedge clk);
      check("t6_no_resp", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    set_m(0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
    set_m(1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0);
    step();
    check("t6_first_m0", 32'(m0_gnt), 32'd1);
    idle_all();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
